// File: rtl/sqed_mem_pkg.sv
// Shared definitions for the SQED memory port: datapath widths, the
// transaction FSM state type and a saturating counter increment.
package sqed_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sqed_mem_if.sv
// CPU-side memory request/response bus (PicoRV32-style valid/ready).
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb : request, CPU -> memory
//   mem_ready/mem_rdata                              : response, memory -> CPU
interface sqed_mem_if;
  import sqed_mem_pkg::*;

  logic              mem_valid;
  logic              mem_instr;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/sqed_mem_array.sv
// Single-port, byte-enabled WORDS x 32 synchronous storage. No reset.
//   clk       : clock
//   rd_en_i   : load rdata_o from mem[addr_i] on this edge
//   wr_strb_i : per-byte write enables for mem[addr_i]
//   addr_i    : word index
//   wdata_i   : write data
//   rdata_o   : registered read data, holds between reads
module sqed_mem_array
  import sqed_mem_pkg::*;
#(
  parameter  int unsigned WORDS = 32,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rd_en_i,
  input  logic [STRB_W-1:0] wr_strb_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (wr_strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (rd_en_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/sqed_mem_port.sv
// Memory slave for a CPU valid/ready bus with optional wait states,
// out-of-range detection and per-kind completion counters.
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : request/response handshake
//   oob_err          : sticky, set when an out-of-range access completes
//   fetch_cnt/rd_cnt/wr_cnt : saturating completed-access counters
module sqed_mem_port
  import sqed_mem_pkg::*;
#(
  parameter int unsigned WORDS       = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  sqed_mem_if.slave        bus,
  output logic             oob_err,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  // Address decode on the live request (only used in IDLE).
  logic [29:0]   word_off;
  logic          req_oob;
  logic [AW-1:0] req_idx;
  logic          addr_lsb_unused;

  assign word_off        = bus.mem_addr[31:2] - BASE_ADDR[31:2];
  assign req_oob         = (bus.mem_addr[31:2] < BASE_ADDR[31:2]) ||
                           (word_off[29:AW] != '0);
  assign req_idx         = word_off[AW-1:0];
  assign addr_lsb_unused = ^bus.mem_addr[1:0];

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              accept;
  logic              resp;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              instr_q;
  logic              oob_q;
  logic [DATA_W-1:0] rdata_q;
  logic              oob_err_q;
  logic [CNT_W-1:0]  fetch_cnt_q, rd_cnt_q, wr_cnt_q;

  logic              arr_rd_en;
  logic [STRB_W-1:0] arr_strb;
  logic [AW-1:0]     arr_addr;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] resp_rdata;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          accept = 1'b1;
          if (WS == 4'd0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WS;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.mem_valid) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q <= 4'd1) begin
          state_d = ST_RESP;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp = (state_q == ST_RESP);

  // One array port: read at acceptance (live address), write at the edge
  // ending RESP (captured address). The read word is captured before the
  // write lands, so writes return the old contents.
  assign arr_rd_en  = accept && !reset;
  assign arr_strb   = (resp && !oob_q && !reset) ? strb_q : '0;
  assign arr_addr   = resp ? idx_q : req_idx;
  assign resp_rdata = oob_q ? '0 : arr_rdata;

  sqed_mem_array #(.WORDS(WORDS)) u_array (
    .clk       (clk),
    .rd_en_i   (arr_rd_en),
    .wr_strb_i (arr_strb),
    .addr_i    (arr_addr),
    .wdata_i   (wdata_q),
    .rdata_o   (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      instr_q     <= 1'b0;
      oob_q       <= 1'b0;
      rdata_q     <= '0;
      oob_err_q   <= 1'b0;
      fetch_cnt_q <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        idx_q   <= req_idx;
        wdata_q <= bus.mem_wdata;
        strb_q  <= bus.mem_wstrb;
        instr_q <= bus.mem_instr;
        oob_q   <= req_oob;
      end
      if (resp) begin
        rdata_q <= resp_rdata;
        if (oob_q) oob_err_q <= 1'b1;
        if (strb_q != '0)  wr_cnt_q    <= sat_inc(wr_cnt_q);
        else if (instr_q)  fetch_cnt_q <= sat_inc(fetch_cnt_q);
        else               rd_cnt_q    <= sat_inc(rd_cnt_q);
      end
    end
  end

  // Response data is live during RESP and held afterwards.
  assign bus.mem_ready = resp;
  assign bus.mem_rdata = resp ? resp_rdata : rdata_q;
  assign oob_err       = oob_err_q;
  assign fetch_cnt     = fetch_cnt_q;
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;

endmodule

// File: tb/tb_sqed_mem_port.sv
// Bench for sqed_mem_port: three instances (0/3/5 wait states, one with a
// non-zero base) against a word-array reference model.
module tb_sqed_mem_port;
  import sqed_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  valid;
  logic        instr;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;

  sqed_mem_if if0 ();
  sqed_mem_if if1 ();
  sqed_mem_if if2 ();

  assign if0.mem_valid = valid[0];
  assign if1.mem_valid = valid[1];
  assign if2.mem_valid = valid[2];
  assign if0.mem_instr = instr;  assign if1.mem_instr = instr;  assign if2.mem_instr = instr;
  assign if0.mem_addr  = addr;   assign if1.mem_addr  = addr;   assign if2.mem_addr  = addr;
  assign if0.mem_wdata = wdata;  assign if1.mem_wdata = wdata;  assign if2.mem_wdata = wdata;
  assign if0.mem_wstrb = strb;   assign if1.mem_wstrb = strb;   assign if2.mem_wstrb = strb;

  logic [2:0]  rdy;
  logic [31:0] rd [3];
  logic [2:0]  oob;
  logic [15:0] fc [3];
  logic [15:0] rc [3];
  logic [15:0] wc [3];

  assign rdy[0] = if0.mem_ready;  assign rd[0] = if0.mem_rdata;
  assign rdy[1] = if1.mem_ready;  assign rd[1] = if1.mem_rdata;
  assign rdy[2] = if2.mem_ready;  assign rd[2] = if2.mem_rdata;

  sqed_mem_port #(.WORDS(32), .WAIT_STATES(0), .BASE_ADDR(32'h0)) d0 (
    .clk(clk), .reset(reset), .bus(if0), .oob_err(oob[0]),
    .fetch_cnt(fc[0]), .rd_cnt(rc[0]), .wr_cnt(wc[0]));
  sqed_mem_port #(.WORDS(32), .WAIT_STATES(3), .BASE_ADDR(32'h0)) d1 (
    .clk(clk), .reset(reset), .bus(if1), .oob_err(oob[1]),
    .fetch_cnt(fc[1]), .rd_cnt(rc[1]), .wr_cnt(wc[1]));
  sqed_mem_port #(.WORDS(16), .WAIT_STATES(5), .BASE_ADDR(32'h1000)) d2 (
    .clk(clk), .reset(reset), .bus(if2), .oob_err(oob[2]),
    .fetch_cnt(fc[2]), .rd_cnt(rc[2]), .wr_cnt(wc[2]));

  // Reference model
  int unsigned ws_m    [3] = '{0, 3, 5};
  int unsigned words_m [3] = '{32, 32, 16};
  logic [31:0] base_m  [3] = '{32'h0, 32'h0, 32'h1000};
  logic [31:0] mem_m   [3][32];
  bit          known   [3][32];
  int unsigned fcm [3], rcm [3], wcm [3];
  bit          oob_m [3];

  int vectors = 0;
  int errors  = 0;

  function automatic int widx(input int s, input logic [31:0] a);
    logic [31:0] off;
    if (a < base_m[s]) return -1;
    off = (a - base_m[s]) >> 2;
    if (off >= words_m[s]) return -1;
    return int'(off);
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic logic [31:0] rnd_addr(input int s);
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return base_m[s] + words_m[s] * 4 + 4 * $urandom_range(0, 7);
    if (r == 1 && base_m[s] != 0) return base_m[s] - 4 * $urandom_range(1, 4);
    return base_m[s] + 4 * $urandom_range(0, words_m[s] - 1) + $urandom_range(0, 3);
  endfunction

  // One transaction on instance s. b2b: valid was left high by the previous
  // call (one extra IDLE edge before acceptance). keep: leave valid high.
  task automatic txn(input int s, input bit ins, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] st,
                     input bit b2b, input bit keep, output logic [31:0] got);
    int k, lat, acc;
    bit kn;
    logic [31:0] exp;
    k   = widx(s, a);
    kn  = (k < 0) || known[s][k];
    exp = (k < 0) ? 32'h0 : mem_m[s][k];
    acc = b2b ? 2 : 1;
    got = '0;
    @(negedge clk);
    instr = ins; addr = a; wdata = d; strb = st; valid[s] = 1'b1;
    lat = 0;
    while (lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (rdy[s]) break;
      if (lat >= acc) begin
        instr = 1'($urandom); addr = $urandom; wdata = $urandom; strb = 4'($urandom);
      end
    end
    vectors++;
    if (!rdy[s]) begin
      errors++;
      $display("FAIL timeout dut%0d: no mem_ready within %0d cycles, want %0d", s, lat, ws_m[s] + acc);
      valid[s] = 1'b0;
      return;
    end
    vectors++;
    if (lat != int'(ws_m[s]) + acc) begin
      errors++;
      $display("FAIL latency dut%0d: got %0d cycles, want %0d", s, lat, ws_m[s] + acc);
    end
    got = rd[s];
    if (kn) begin
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rdata dut%0d addr %h: got %h want %h", s, a, got, exp);
      end
    end
    if (k < 0) oob_m[s] = 1'b1;
    else if (st != 4'h0) begin
      for (int b = 0; b < 4; b++) if (st[b]) mem_m[s][k][8*b +: 8] = d[8*b +: 8];
      if (st == 4'hF) known[s][k] = 1'b1;
    end
    if (st != 4'h0)  wcm[s] = sat(wcm[s]);
    else if (ins)    fcm[s] = sat(fcm[s]);
    else             rcm[s] = sat(rcm[s]);
    if (!keep) begin
      valid[s] = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (rdy[s] !== 1'b0 || rd[s] !== got) begin
        errors++;
        $display("FAIL after-resp dut%0d: got ready %b rdata %h want ready 0 rdata %h", s, rdy[s], rd[s], got);
      end
      vectors++;
      if ({oob[s], fc[s], rc[s], wc[s]} !== {oob_m[s], 16'(fcm[s]), 16'(rcm[s]), 16'(wcm[s])}) begin
        errors++;
        $display("FAIL status dut%0d: got oob %b f/r/w %0d/%0d/%0d want oob %b f/r/w %0d/%0d/%0d",
                 s, oob[s], fc[s], rc[s], wc[s], oob_m[s], fcm[s], rcm[s], wcm[s]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if ({rdy[s], rd[s], oob[s], fc[s], rc[s], wc[s]} !== '0) begin
        errors++;
        $display("FAIL %s dut%0d: got ready %b rdata %h oob %b f/r/w %0d/%0d/%0d want all 0",
                 tag, s, rdy[s], rd[s], oob[s], fc[s], rc[s], wc[s]);
      end
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      fcm[s] = 0; rcm[s] = 0; wcm[s] = 0; oob_m[s] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = '0; instr = 1'b0; addr = '0; wdata = '0; strb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] g;
    txn(0, 1'b0, 32'h8, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, g);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, g);
    vectors++;
    if (g !== 32'hDEADBEEF || wc[0] !== 16'd1 || rc[0] !== 16'd1) begin
      errors++;
      $display("FAIL basic: got rdata %h wr %0d rd %0d want deadbeef 1 1", g, wc[0], rc[0]);
    end
  endtask

  task automatic test_latency();
    logic [31:0] g;
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0, g);
  endtask

  task automatic test_init();
    logic [31:0] g;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < int'(words_m[s]); k++)
        txn(s, 1'b0, base_m[s] + 32'(4 * k), $urandom, 4'hF, 1'b0, 1'b0, g);
  endtask

  task automatic test_strobe();
    logic [31:0] g;
    txn(0, 1'b0, 32'h10, 32'h11223344, 4'hF, 1'b0, 1'b0, g);
    txn(0, 1'b0, 32'h10, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, g);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, g);
    vectors++;
    if (g !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe merge: got %h want 11bb33dd", g);
    end
  endtask

  task automatic test_oob();
    logic [31:0] g;
    txn(0, 1'b0, 32'h0, 32'h55AA00FF, 4'hF, 1'b0, 1'b0, g);
    txn(0, 1'b0, 32'h80, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, g);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, g);
    vectors++;
    if (g !== 32'h55AA00FF || oob[0] !== 1'b1) begin
      errors++;
      $display("FAIL oob: got word0 %h oob %b want 55aa00ff 1", g, oob[0]);
    end
    txn(2, 1'b0, 32'h0FFC, 32'h12345678, 4'hF, 1'b0, 1'b0, g);
    txn(2, 1'b1, 32'h1040, 32'h0, 4'h0, 1'b0, 1'b0, g);
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    txn(1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, g);
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b1, g);
    txn(1, 1'b1, 32'h24, 32'h0, 4'h0, 1'b1, 1'b0, g);
  endtask

  task automatic test_abort();
    logic [31:0] g;
    bit seen;
    txn(2, 1'b0, 32'h1008, 32'h0BADC0DE, 4'hF, 1'b0, 1'b0, g);
    @(negedge clk);
    instr = 1'b0; addr = 32'h1008; wdata = 32'hFFFFFFFF; strb = 4'hF; valid[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    valid[2] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rdy[2]) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL abort: got mem_ready 1 want 0");
    end
    txn(2, 1'b0, 32'h1008, 32'h0, 4'h0, 1'b0, 1'b0, g);
  endtask

  task automatic test_reset_mid();
    logic [31:0] g;
    @(negedge clk);
    instr = 1'b0; addr = 32'h20; wdata = 32'h0; strb = 4'hF; valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset-mid");
    model_reset();
    @(negedge clk);
    reset = 1'b0; valid = '0;
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, g);
  endtask

  task automatic test_saturate();
    logic [31:0] g;
    @(negedge clk);
    force d0.fetch_cnt_q = 16'hFFFE;
    #1;
    release d0.fetch_cnt_q;
    fcm[0] = 65534;
    for (int i = 0; i < 3; i++) txn(0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, g);
    vectors++;
    if (fc[0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate: got fetch_cnt %h want ffff", fc[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] g;
    bit prev, kp;
    for (int s = 0; s < 3; s++) begin
      prev = 1'b0;
      for (int i = 0; i < 30; i++) begin
        kp = (i != 29) && ($urandom_range(0, 3) == 0);
        txn(s, 1'($urandom), rnd_addr(s), $urandom,
            ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), prev, kp, g);
        prev = kp;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_init();
    test_strobe();
    test_oob();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
